io_text_loader: RTL and testbench
=================================

// Module: io_text_loader
// PURPOSE
// Host-side I/O engine for the pipelined core. Accepts a byte stream and writes it
// one char per word into data memory, along with the char count. Pulses the core's
// start input, then waits for the core's I/O-done flag. Reads the processed chars
// back and streams them out. Sits between the external byte link and the memory
// write/read port shared with the core.
// PARAMETERS
// WIDTH          36   data-memory word / address width
// MAX_CHARS      100  buffer size in chars (input and output)
// IN_BASE        0    word address of first input char
// OUT_BASE       100  word address of first output char
// LEN_ADDR       200  word address receiving the char count
// TIMEOUT_CYCLES 4096 run watchdog limit (used only with IO_LOADER_TIMEOUT_EN)
// PORTS
// clock      in   1      single clock, all logic rising-edge
// reset      in   1      synchronous, active-high
// in_data    in   8      input char
// in_valid   in   1      input char valid
// in_last    in   1      final char of message (qualified by in_valid)
// in_ready   out  1      loader accepts in_data this cycle
// mem_we     out  1      data-memory write enable
// mem_addr   out  WIDTH  data-memory word address (write and read)
// mem_wdata  out  WIDTH  write data, {zeros, char} or count
// mem_rdata  in   WIDTH  read data, valid 1 cycle after mem_addr
// start_io   out  1      one-cycle start pulse to core
// done_flag  in   1      core I/O-done level
// out_data   out  8      output char = mem_rdata[7:0]
// out_valid  out  1      output char valid
// out_last   out  1      final output char
// out_ready  in   1      downstream accepts out_data
// busy       out  1      state != IDLE
// overflow   out  1      sticky: MAX_CHARS reached without in_last
// BEHAVIOUR
// - Reset: state=IDLE, count=0, idx=0. All outputs 0 except in_ready=1 from the 1st cycle after reset.
// - States: IDLE -> LOAD -> LENW -> START -> RUN -> DRAIN -> IDLE.
// - IDLE/LOAD:
//   - in_ready=1. Accept = in_valid&in_ready.
//   - Each accept registers a write on the next cycle: mem_we=1, mem_addr=IN_BASE+count, mem_wdata={(WIDTH-8)'0,in_data}; count++.
//   - IDLE moves to LOAD on the first accept.
// - Load end:
//   - Accept with in_last -> LENW.
//   - Accept making count==MAX_CHARS without in_last -> LENW, overflow=1.
//   - in_ready=0 from the next cycle. Count is always 1..MAX_CHARS.
// - LENW: one cycle, mem_we=1, mem_addr=LEN_ADDR, mem_wdata=count.
// - START: start_io=1 for exactly one cycle, mem_we=0.
// - RUN:
//   - done_flag is sampled from the cycle after start_io. A stale high during LOAD/LENW/START is ignored.
//   - done_flag=1 -> DRAIN with idx=0.
// - DRAIN:
//   - Issue read mem_addr=OUT_BASE+idx. Next cycle out_data=mem_rdata[7:0] registered, out_valid=1.
//   - out_last=(idx==count-1).
//   - out_data/out_valid held stable until out_ready. On handshake: idx++ and next read issued.
//   - Peak rate: 1 char / 2 cycles.
//   - Handshake with out_last -> IDLE, count cleared. overflow stays set until the next accept in IDLE.
// - mem_we is never asserted outside LOAD-write cycles and LENW. No read is issued outside DRAIN.
// - Reset mid-operation (any state): next cycle is IDLE. start_io, mem_we and out_valid drop immediately; overflow cleared.
// - Address arithmetic is WIDTH-bit unsigned. The bases are a configuration constraint: buffers must not overlap.
// CONFIGURATION
// - IO_LOADER_TIMEOUT_EN defined:
//   - RUN counts cycles; reaching TIMEOUT_CYCLES without done_flag -> IDLE.
//   - Adds output timeout (1 bit, sticky, cleared on the next accept in IDLE and on reset).
// - IO_LOADER_TIMEOUT_EN undefined: no counter, no timeout port; RUN waits indefinitely.
// TESTING
// - Send "AB" (0x41, 0x42+in_last):
//   - expect writes [0]=0x41, [1]=0x42, [200]=2; then start_io for 1 cycle; busy=1.
// - Preload mem[100..101]=0x61,0x62, raise done_flag:
//   - expect out 0x61, then 0x62 with out_last; then IDLE, busy=0.
// - Hold out_ready=0 for 5 cycles in DRAIN:
//   - out_data stable, no new read issued, idx unchanged.
// - Send 101 bytes, no in_last:
//   - 100 writes, overflow=1, in_ready=0 after the 100th.
//   - [200]=100; the 101st byte is not accepted.
// - done_flag held high before and through load:
//   - start_io still pulses; DRAIN starts only in the cycle after start_io.
// - Assert reset mid-DRAIN:
//   - next cycle out_valid=0, state IDLE, in_ready=1, overflow=0.
//   - With IO_LOADER_TIMEOUT_EN: no done_flag for TIMEOUT_CYCLES -> timeout=1, IDLE.

Source files
------------

// File: rtl/io_text_loader.sv
// Host I/O engine: loads a byte stream into data memory, starts the core, drains results.
// Optional run watchdog and timeout port under IO_LOADER_TIMEOUT_EN.
module io_text_loader #(
    parameter int WIDTH          = 36,
    parameter int MAX_CHARS      = 100,
    parameter int IN_BASE        = 0,
    parameter int OUT_BASE       = 100,
    parameter int LEN_ADDR       = 200,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [7:0]       in_data_i,
    input  logic             in_valid_i,
    input  logic             in_last_i,
    output logic             in_ready_o,
    output logic             mem_we_o,
    output logic [WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    input  logic [WIDTH-1:0] mem_rdata_i,
    output logic             start_io_o,
    input  logic             done_flag_i,
    output logic [7:0]       out_data_o,
    output logic             out_valid_o,
    output logic             out_last_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             overflow_o
`ifdef IO_LOADER_TIMEOUT_EN
   ,output logic             timeout_o
`endif
);

    localparam int CW = $clog2(MAX_CHARS + 1);

    typedef enum logic [2:0] {IDLE, LOAD, LENW, START, RUN, DRAIN} state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q, idx_q;
    logic             in_ready_q, mem_we_q, start_io_q;
    logic [WIDTH-1:0] mem_addr_q, mem_wdata_q;
    logic [7:0]       out_data_q;
    logic             out_valid_q, out_last_q, overflow_q;
    logic             first_q, rd_pend_q;

    logic             accept, fire, next_rd;
    logic [CW-1:0]    count_d, idx_d;
    logic [WIDTH-1:0] rd_addr_d;
    logic             unused_rdata;

`ifdef IO_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;
    logic          timeout_q;
    assign timeout_o = timeout_q;
`endif

    assign accept    = in_valid_i & in_ready_q;
    assign fire      = (state_q == DRAIN) & out_valid_q & out_ready_i;
    assign next_rd   = fire & ~out_last_q;
    assign count_d   = count_q + CW'(1);
    assign idx_d     = idx_q + CW'(1);
    assign rd_addr_d = WIDTH'(OUT_BASE) + WIDTH'(idx_d);

    // The next read goes out in the handshake cycle itself to reach 2 cycles/char.
    assign mem_addr_o   = next_rd ? rd_addr_d : mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_we_o     = mem_we_q & ~reset_i;
    assign start_io_o   = start_io_q & ~reset_i;
    assign out_valid_o  = out_valid_q & ~reset_i;
    assign out_data_o   = out_data_q;
    assign out_last_o   = out_last_q;
    assign in_ready_o   = in_ready_q;
    assign overflow_o   = overflow_q;
    assign busy_o       = (state_q != IDLE);
    assign unused_rdata = ^mem_rdata_i[WIDTH-1:8];

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            count_q     <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            start_io_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
            first_q     <= 1'b0;
            rd_pend_q   <= 1'b0;
`ifdef IO_LOADER_TIMEOUT_EN
            tmo_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            mem_we_q   <= 1'b0;
            start_io_q <= 1'b0;
            first_q    <= 1'b0;
            rd_pend_q  <= 1'b0;
            unique case (state_q)
                IDLE, LOAD: begin
                    if (accept) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= WIDTH'(IN_BASE) + WIDTH'(count_q);
                        mem_wdata_q <= {{(WIDTH-8){1'b0}}, in_data_i};
                        count_q     <= count_d;
                        state_q     <= LOAD;
                        if (state_q == IDLE) begin
                            overflow_q <= 1'b0;
`ifdef IO_LOADER_TIMEOUT_EN
                            timeout_q  <= 1'b0;
`endif
                        end
                        if (in_last_i || count_d == CW'(MAX_CHARS)) begin
                            state_q    <= LENW;
                            in_ready_q <= 1'b0;
                            if (!in_last_i) overflow_q <= 1'b1;
                        end
                    end
                end
                LENW: begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= WIDTH'(LEN_ADDR);
                    mem_wdata_q <= WIDTH'(count_q);
                    state_q     <= START;
                end
                START: begin
                    start_io_q <= 1'b1;
                    state_q    <= RUN;
`ifdef IO_LOADER_TIMEOUT_EN
                    tmo_q      <= '0;
`endif
                end
                RUN: begin
                    // done_flag during the start pulse may be left over from the previous run
                    if (!start_io_q && done_flag_i) begin
                        state_q    <= DRAIN;
                        idx_q      <= '0;
                        mem_addr_q <= WIDTH'(OUT_BASE);
                        first_q    <= 1'b1;
                    end
`ifdef IO_LOADER_TIMEOUT_EN
                    else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_q    <= IDLE;
                        count_q    <= '0;
                        in_ready_q <= 1'b1;
                        timeout_q  <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
`endif
                end
                DRAIN: begin
                    rd_pend_q <= first_q | next_rd;
                    if (rd_pend_q) begin
                        out_data_q  <= mem_rdata_i[7:0];
                        out_valid_q <= 1'b1;
                        out_last_q  <= (idx_q == count_q - CW'(1));
                    end
                    if (fire) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            state_q    <= IDLE;
                            count_q    <= '0;
                            out_last_q <= 1'b0;
                            in_ready_q <= 1'b1;
                        end else begin
                            idx_q      <= idx_d;
                            mem_addr_q <= rd_addr_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_text_loader.sv
// Randomized bench for io_text_loader against a transaction-level memory/stream model.
// Define IO_LOADER_TIMEOUT_EN to also exercise the run watchdog.
module tb_io_text_loader;

    localparam int W   = 36;
    localparam int MAX = 100;
    localparam int TMO = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0, in_last = 1'b0;
    logic          in_ready;
    logic          mem_we;
    logic [W-1:0]  mem_addr, mem_wdata;
    logic [W-1:0]  mem_rdata = '0;
    logic          start_io;
    logic          done_flag = 1'b0;
    logic [7:0]    out_data;
    logic          out_valid, out_last;
    logic          out_ready = 1'b0;
    logic          busy, overflow;
`ifdef IO_LOADER_TIMEOUT_EN
    logic          timeout;
`endif

    io_text_loader dut (
        .clock_i(clk), .reset_i(rst),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_last_i(in_last),
        .in_ready_o(in_ready),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata),
        .start_io_o(start_io), .done_flag_i(done_flag),
        .out_data_o(out_data), .out_valid_o(out_valid), .out_last_o(out_last),
        .out_ready_i(out_ready),
        .busy_o(busy), .overflow_o(overflow)
`ifdef IO_LOADER_TIMEOUT_EN
       ,.timeout_o(timeout)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, fails = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [W-1:0] mem [0:255];
    logic [W-1:0] wa[$], wd[$];
    logic [7:0]   oq[$];
    bit           lq[$];
    int           hs[$];
    int           cyc = 0, starts = 0, start_cyc = 0, first_ov = -1;

    always @(posedge clk) begin
        cyc = cyc + 1;
        mem_rdata <= (mem_addr < 256) ? mem[mem_addr[7:0]] : '0;
        if (!rst) begin
            if (mem_we === 1'b1) begin
                wa.push_back(mem_addr);
                wd.push_back(mem_wdata);
                mem[mem_addr[7:0]] = mem_wdata;
            end
            if (start_io === 1'b1) begin
                starts = starts + 1;
                start_cyc = cyc;
            end
            if (out_valid === 1'b1 && first_ov < 0) first_ov = cyc;
            if (out_valid === 1'b1 && out_ready) begin
                oq.push_back(out_data);
                lq.push_back(out_last);
                hs.push_back(cyc);
            end
        end
    end

    logic [7:0] msg [0:MAX];
    logic [7:0] pre [0:MAX-1];
    int         cnt_exp;
    bit         ovf_exp, pre_done_g;

    task automatic load_phase(input int n, input bit last, input bit pre_done,
                              input bit ab);
        int acc, k;
        wa.delete(); wd.delete(); oq.delete(); lq.delete(); hs.delete();
        starts = 0; first_ov = -1;
        for (int i = 0; i < MAX; i++) begin
            pre[i] = 8'($urandom_range(0, 255));
            mem[100+i] = {28'($urandom), pre[i]};
        end
        for (int i = 0; i <= MAX; i++) msg[i] = 8'($urandom_range(32, 126));
        if (ab) begin
            msg[0] = 8'h41; msg[1] = 8'h42;
            pre[0] = 8'h61; pre[1] = 8'h62;
            mem[100] = {28'h0, 8'h61};
            mem[101] = {28'h0, 8'h62};
        end
        acc = (n > MAX) ? MAX : n;
        cnt_exp = acc;
        ovf_exp = !(last && n <= MAX);
        pre_done_g = pre_done;
        done_flag = pre_done;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            in_valid = 1'b1;
            in_data = msg[i];
            in_last = last && (i == n - 1);
            if (i >= MAX) begin
                repeat (3) begin
                    chk("in_ready_full", in_ready, 1'b0);
                    @(negedge clk);
                end
            end else begin
                k = 0;
                while (!in_ready && k < 50) begin
                    @(negedge clk);
                    k++;
                end
                if (!in_ready) chk("in_ready_wait", in_ready, 1'b1);
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        k = 0;
        while (starts == 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk("start_pulses", starts, 1);
        chk("busy_run", busy, 1'b1);
        chk("in_ready_run", in_ready, 1'b0);
        chk("overflow", overflow, ovf_exp);
        chk("wr_count", wa.size(), acc + 1);
        for (int i = 0; i <= acc && i < wa.size(); i++) begin
            if (i < acc)
                chk("wr_char", {wa[i], wd[i]}, {W'(i), W'(msg[i])});
            else
                chk("wr_len", {wa[i], wd[i]}, {W'(200), W'(acc)});
        end
    endtask

    task automatic drain_phase(input bit rmode, input bit stall,
                               input bit do_reset);
        int k;
        logic [7:0]   d0;
        logic [W-1:0] a0;
        out_ready = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        done_flag = 1'b1;
        if (stall || do_reset) begin
            k = 0;
            while (!out_valid && k < 50) begin
                @(negedge clk);
                k++;
            end
            chk("first_valid", out_valid, 1'b1);
        end
        if (stall) begin
            d0 = out_data;
            a0 = mem_addr;
            repeat (5) begin
                @(negedge clk);
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", out_data, d0);
                chk("stall_addr", mem_addr, a0);
            end
        end
        if (do_reset) begin
            rst = 1'b1;
            #1 chk("rst_out_valid", out_valid, 1'b0);
            @(negedge clk);
            rst = 1'b0;
            done_flag = 1'b0;
            chk("rst_busy", busy, 1'b0);
            chk("rst_in_ready", in_ready, 1'b1);
            chk("rst_overflow", overflow, 1'b0);
            chk("rst_out_valid2", out_valid, 1'b0);
            return;
        end
        k = 0;
        while (busy && k < 3000) begin
            out_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            k++;
        end
        out_ready = 1'b0;
        done_flag = 1'b0;
        chk("drain_idle", busy, 1'b0);
        chk("in_ready_idle", in_ready, 1'b1);
        chk("ovf_hold", overflow, ovf_exp);
        if (pre_done_g) chk("stale_order", first_ov > start_cyc, 1'b1);
        chk("out_count", oq.size(), cnt_exp);
        for (int i = 0; i < oq.size() && i < cnt_exp; i++) begin
            chk("out_char", oq[i], pre[i]);
            chk("out_last", lq[i], i == cnt_exp - 1);
        end
        if (!rmode)
            for (int i = 1; i < hs.size(); i++)
                chk("out_rate", hs[i] - hs[i-1], 2);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready0", in_ready, 1'b1);
        chk("rst_busy0", busy, 1'b0);
        chk("rst_we0", mem_we, 1'b0);
        chk("rst_start0", start_io, 1'b0);
        chk("rst_ovalid0", out_valid, 1'b0);
        chk("rst_ovf0", overflow, 1'b0);

        load_phase(2, 1'b1, 1'b0, 1'b1);
        drain_phase(1'b0, 1'b0, 1'b0);

        load_phase($urandom_range(3, 10), 1'b1, 1'b0, 1'b0);
        drain_phase(1'b1, 1'b1, 1'b0);

        load_phase($urandom_range(2, 6), 1'b1, 1'b1, 1'b0);
        drain_phase(1'b1, 1'b0, 1'b0);

        for (int t = 0; t < 3; t++) begin
            load_phase($urandom_range(1, MAX), 1'b1, 1'b0, 1'b0);
            drain_phase(t == 0 ? 1'b0 : 1'b1, 1'b0, 1'b0);
        end
        load_phase(MAX, 1'b1, 1'b0, 1'b0);
        drain_phase(1'b0, 1'b0, 1'b0);

        load_phase(MAX + 1, 1'b0, 1'b0, 1'b0);
        drain_phase(1'b1, 1'b0, 1'b0);

        load_phase(5, 1'b1, 1'b0, 1'b0);
        drain_phase(1'b1, 1'b0, 1'b0);

        load_phase(MAX + 1, 1'b0, 1'b0, 1'b0);
        drain_phase(1'b1, 1'b0, 1'b1);

`ifdef IO_LOADER_TIMEOUT_EN
        begin
            int k;
            load_phase(3, 1'b1, 1'b0, 1'b0);
            k = 0;
            while (busy && k < TMO + 50) begin
                @(negedge clk);
                k++;
            end
            chk("tmo_idle", busy, 1'b0);
            chk("tmo_flag", timeout, 1'b1);
            chk("tmo_late", k > TMO - 10, 1'b1);
            load_phase(4, 1'b1, 1'b0, 1'b0);
            chk("tmo_clear", timeout, 1'b0);
            drain_phase(1'b1, 1'b0, 1'b0);
        end
`endif

        load_phase($urandom_range(1, 8), 1'b1, 1'b0, 1'b0);
        drain_phase(1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
